// File: rtl/btn_conditioner.sv
// btn_conditioner: N-channel push-button synchroniser and debouncer that also
// raises one-cycle press, release, long-press and auto-repeat events.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   btn_i     raw button pins, one per channel
//   btn_o     debounced level, 1 = pressed
//   press_o   one-cycle pulse on a btn_o rise
//   release_o one-cycle pulse on a btn_o fall
//   long_o    one-cycle pulse when a hold reaches LONG_TICKS ticks
//   repeat_o  one-cycle pulse every REPEAT_TICKS ticks after long_o
//   tick_o    internal time-base strobe
module btn_conditioner #(
    parameter int               CLK_FREQ       = 12_000_000,
    parameter int               TICK_FREQ      = 1000,
    parameter int               N_BTN          = 2,
    parameter int               DEBOUNCE_TICKS = 10,
    parameter int               LONG_TICKS     = 500,
    parameter int               REPEAT_TICKS   = 100,
    parameter logic [N_BTN-1:0] INVERT         = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] repeat_o,
    output logic             tick_o
);

    localparam int DIV  = CLK_FREQ / TICK_FREQ;
    localparam int CW   = $clog2(DIV);
    localparam int DBW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'((LONG_TICKS > 0) ? LONG_TICKS - 1 : 0);
    localparam logic [HW-1:0]  LONG_SAT  = HW'(LONG_TICKS);
    localparam logic [HW-1:0]  REP_LAST  = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam logic           LONG_EN   = (LONG_TICKS > 0);
    localparam logic           REP_EN    = (REPEAT_TICKS > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    logic [CW-1:0] r_div;
    logic          r_tick;

    // tick is high in the cycle after the divider wraps: 1 cycle in DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            if (r_div == DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + CW'(1);
            end
        end
    end

    assign tick_o = r_tick;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [1:0]     r_sync;
        logic           w_in;
        logic           r_btn;
        logic [DBW-1:0] r_db;
        logic [DBW-1:0] w_db_nx;
        logic           w_tog;
        state_t         r_st;
        state_t         w_st_nx;
        logic [HW-1:0]  r_hc;
        logic [HW-1:0]  w_hc_nx;
        logic           w_long_nx;
        logic           w_rep_nx;
        logic           r_press;
        logic           r_rel;
        logic           r_long;
        logic           r_rep;

        assign w_in = r_sync[1] ^ INVERT[g];

        // Any sample agreeing with btn_o restarts the count, tick or not
        always_comb begin
            w_tog   = 1'b0;
            w_db_nx = r_db;
            if (w_in == r_btn) begin
                w_db_nx = '0;
            end else if (r_tick) begin
                if (r_db == DB_LAST) begin
                    w_tog   = 1'b1;
                    w_db_nx = '0;
                end else begin
                    w_db_nx = r_db + DBW'(1);
                end
            end
        end

        // btn_o is 1 throughout HOLD/REPEAT, so a toggle there is a fall;
        // the fall wins over any long/repeat due on the same tick
        always_comb begin
            w_st_nx   = r_st;
            w_hc_nx   = r_hc;
            w_long_nx = 1'b0;
            w_rep_nx  = 1'b0;
            unique case (r_st)
                S_IDLE: begin
                    if (LONG_EN && w_tog && !r_btn) begin
                        w_st_nx = S_HOLD;
                        w_hc_nx = '0;
                    end
                end
                S_HOLD: begin
                    if (w_tog) begin
                        w_st_nx = S_IDLE;
                        w_hc_nx = '0;
                    end else if (r_tick) begin
                        if (r_hc == LONG_LAST) begin
                            w_long_nx = 1'b1;
                            if (REP_EN) begin
                                w_st_nx = S_REPEAT;
                                w_hc_nx = '0;
                            end else begin
                                w_hc_nx = LONG_SAT;
                            end
                        end else if (r_hc < LONG_LAST) begin
                            w_hc_nx = r_hc + HW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (w_tog) begin
                        w_st_nx = S_IDLE;
                        w_hc_nx = '0;
                    end else if (r_tick) begin
                        if (r_hc == REP_LAST) begin
                            w_rep_nx = 1'b1;
                            w_hc_nx  = '0;
                        end else begin
                            w_hc_nx = r_hc + HW'(1);
                        end
                    end
                end
                default: begin
                    w_st_nx = S_IDLE;
                    w_hc_nx = '0;
                end
            endcase
        end

        // Sync FFs reset to the idle pin level so the channel reads released
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync  <= {2{INVERT[g]}};
                r_btn   <= 1'b0;
                r_db    <= '0;
                r_st    <= S_IDLE;
                r_hc    <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], btn_i[g]};
                r_btn   <= r_btn ^ w_tog;
                r_db    <= w_db_nx;
                r_st    <= w_st_nx;
                r_hc    <= w_hc_nx;
                r_press <= w_tog & ~r_btn;
                r_rel   <= w_tog & r_btn;
                r_long  <= w_long_nx;
                r_rep   <= w_rep_nx;
            end
        end

        assign btn_o[g]     = r_btn;
        assign press_o[g]   = r_press;
        assign release_o[g] = r_rel;
        assign long_o[g]    = r_long;
        assign repeat_o[g]  = r_rep;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus for btn_conditioner,
// checked every cycle against a tick-counting reference model.
module tb_btn_conditioner;

    localparam int         DIV  = 10;
    localparam int         DB   = 3;
    localparam int         LONG = 5;
    localparam int         REP  = 2;
    localparam logic [1:0] INV  = 2'b10;

    logic       clk;
    logic       rst;
    logic [1:0] btn_i;
    logic [1:0] btn_o;
    logic [1:0] press_o;
    logic [1:0] release_o;
    logic [1:0] long_o;
    logic [1:0] repeat_o;
    logic       tick_o;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    btn_conditioner #(
        .CLK_FREQ      (100),
        .TICK_FREQ     (10),
        .N_BTN         (2),
        .DEBOUNCE_TICKS(DB),
        .LONG_TICKS    (LONG),
        .REPEAT_TICKS  (REP),
        .INVERT        (INV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .btn_o    (btn_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .tick_o   (tick_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: cycle c is the cycle after edge c since reset release.
    // Ticks fall on cycles that are positive multiples of DIV; the output
    // follows an input after DB ticks of uninterrupted disagreement, and hold
    // events come from the number of ticks elapsed since the rise.
    int         m_e        = 0;
    logic [1:0] m_h1       = INV;
    logic [1:0] m_h2       = INV;
    logic [1:0] m_b        = '0;
    logic [1:0] m_press    = '0;
    logic [1:0] m_rel      = '0;
    logic [1:0] m_long     = '0;
    logic [1:0] m_rep      = '0;
    logic       m_tick     = 1'b0;
    int         m_start[2] = '{-1, -1};
    int         m_rise[2]  = '{0, 0};

    function automatic int tk(input int c);
        return (c <= 0) ? 0 : c / DIV;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_e = 0;
            m_h1 = INV;
            m_h2 = INV;
            m_b = '0;
            m_press = '0;
            m_rel = '0;
            m_long = '0;
            m_rep = '0;
            m_tick = 1'b0;
            m_start = '{-1, -1};
        end else begin
            int         cp;
            logic [1:0] s;
            logic       t;
            cp = m_e;
            s = m_h2 ^ INV;
            t = (cp > 0) && (cp % DIV == 0);
            m_press = '0;
            m_rel = '0;
            m_long = '0;
            m_rep = '0;
            for (int ch = 0; ch < 2; ch++) begin
                logic tog;
                int   k;
                tog = 1'b0;
                if (s[ch] == m_b[ch]) begin
                    m_start[ch] = -1;
                end else begin
                    if (m_start[ch] < 0) m_start[ch] = cp;
                    if (tk(cp) - tk(m_start[ch] - 1) >= DB) begin
                        tog = 1'b1;
                        m_b[ch] = ~m_b[ch];
                        m_start[ch] = -1;
                        if (m_b[ch]) begin
                            m_press[ch] = 1'b1;
                            m_rise[ch] = tk(cp);
                        end else begin
                            m_rel[ch] = 1'b1;
                        end
                    end
                end
                if (!tog && m_b[ch] && t) begin
                    k = tk(cp) - m_rise[ch];
                    if (k == LONG) m_long[ch] = 1'b1;
                    else if (k > LONG && (k - LONG) % REP == 0) m_rep[ch] = 1'b1;
                end
            end
            m_e++;
            m_tick = (m_e % DIV == 0);
            m_h2 = m_h1;
            m_h1 = btn_i;
        end
    end

    initial forever begin
        @(negedge clk);
        check("btn", {30'd0, btn_o}, {30'd0, m_b});
        check("press", {30'd0, press_o}, {30'd0, m_press});
        check("release", {30'd0, release_o}, {30'd0, m_rel});
        check("long", {30'd0, long_o}, {30'd0, m_long});
        check("repeat", {30'd0, repeat_o}, {30'd0, m_rep});
        check("tick", {31'd0, tick_o}, {31'd0, m_tick});
    end

    function automatic logic [1:0] ev(input int kind);
        case (kind)
            0: return press_o;
            1: return release_o;
            2: return long_o;
            3: return repeat_o;
            default: return btn_o;
        endcase
    endfunction

    task automatic wait_ev(input string tag, input int kind, input int ch,
                           input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ev(kind)[ch]) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_seen"}, {31'd0, at >= 0}, 32'd1);
    endtask

    int t0;
    int tp;
    int tl;
    int tr;
    int act;
    int lat;

    initial begin
        rst = 1'b1;
        btn_i = INV;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state",
              {21'd0, btn_o, press_o, release_o, long_o, repeat_o, tick_o},
              32'd0);
        rst = 1'b1;

        // clean press, long, repeats, release
        repeat (5) @(negedge clk);
        btn_i[0] = 1'b1;
        t0 = cyc;
        wait_ev("cp_press", 0, 0, 40, tp);
        lat = tp - t0;
        check("cp_lat", {31'd0, lat >= 23 && lat <= 33}, 32'd1);
        check("cp_btn0", {31'd0, btn_o[0]}, 32'd1);
        check("cp_ch1", {31'd0, btn_o[1]}, 32'd0);
        wait_ev("cp_long", 2, 0, 60, tl);
        check("long_dt", tl - tp, 32'd50);
        wait_ev("cp_rep1", 3, 0, 30, tr);
        check("rep1_dt", tr - tp, 32'd70);
        wait_ev("cp_rep2", 3, 0, 30, tr);
        check("rep2_dt", tr - tp, 32'd90);
        while (cyc < tp + 150) @(negedge clk);
        btn_i[0] = 1'b0;
        wait_ev("cp_rel", 1, 0, 40, tr);
        check("rel_norep", {31'd0, repeat_o[0]}, 32'd0);
        check("rel_nolong", {31'd0, long_o[0]}, 32'd0);

        // bounce rejection
        repeat (20) @(negedge clk);
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            act += int'(btn_o[0] | press_o[0] | release_o[0]);
            if (i % 15 == 0) btn_i[0] = ~btn_i[0];
        end
        check("bounce_quiet", act, 32'd0);
        btn_i[0] = 1'b1;
        wait_ev("bounce_press", 0, 0, 40, tp);
        btn_i[0] = 1'b0;
        wait_ev("bounce_rel", 1, 0, 40, tr);

        // active-low channel 1, then simultaneous press0/release1
        repeat (10) @(negedge clk);
        btn_i[1] = 1'b0;
        wait_ev("inv_press", 0, 1, 40, tp);
        repeat (7) @(negedge clk);
        btn_i = 2'b11;
        wait_ev("sim_press0", 0, 0, 40, tp);
        check("sim_rel1", {31'd0, release_o[1]}, 32'd1);
        check("sim_nopress1", {31'd0, press_o[1]}, 32'd0);
        btn_i = INV;
        repeat (40) @(negedge clk);

        // random holds and bounces, checked by the model every cycle
        for (int s = 0; s < 40; s++) begin
            btn_i = 2'($urandom);
            repeat ($urandom_range(1, 120)) @(negedge clk);
        end

        // reset while repeating with the button still held
        btn_i = INV;
        repeat (40) @(negedge clk);
        btn_i[0] = 1'b1;
        wait_ev("rr_press", 0, 0, 40, tp);
        wait_ev("rr_rep", 3, 0, 100, tr);
        #2 rst = 1'b0;
        #1 check("rst_async",
                 {21'd0, btn_o, press_o, release_o, long_o, repeat_o, tick_o},
                 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        t0 = cyc;
        wait_ev("rr_repress", 0, 0, 40, tp);
        lat = tp - t0;
        check("rr_lat", {31'd0, lat >= 23 && lat <= 33}, 32'd1);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
